// File: rtl/rv_pkg.sv
// Shared RISC-V fetch definitions: opcode classes, NOP encoding, default
// reset vector and the branch-history counter helpers.
package rv_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

    // inst[6:2] values that mark control-flow instructions
    localparam logic [4:0]  OP_BRANCH = 5'b11000;
    localparam logic [4:0]  OP_JAL    = 5'b11011;
    localparam logic [4:0]  OP_JALR   = 5'b11001;

    // addi x0, x0, 0
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Weakly not-taken starting point for every history counter
    localparam logic [1:0]  CTR_INIT = 2'b01;

    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JAL,
        CF_JALR
    } cf_kind_t;

    // Map the major opcode field onto a control-flow class
    function automatic cf_kind_t classify(input logic [4:0] opcode);
        cf_kind_t kind;
        case (opcode)
            OP_BRANCH: kind = CF_BRANCH;
            OP_JAL:    kind = CF_JAL;
            OP_JALR:   kind = CF_JALR;
            default:   kind = CF_NONE;
        endcase
        return kind;
    endfunction

    // Two-bit saturating step: taken climbs toward 3, not-taken falls toward 0
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] next;
        next = ctr;
        if (taken) begin
            if (ctr != 2'b11) next = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) next = ctr - 2'b01;
        end
        return next;
    endfunction

endpackage

// File: rtl/bht.sv
// Branch history table: one 2-bit saturating counter per entry. The read
// port is combinational and always sees the value before this cycle's update.
module bht
    import rv_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr [ENTRIES];

    // Counter storage: reset every entry to weakly not-taken, then train on resolved branches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            ctr[upd_idx] <= sat_update(ctr[upd_idx], upd_taken);
        end
    end

    assign rd_taken = ctr[rd_idx][1];

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator and IF/ID pipeline register.
// Next-PC priority: redirect, stall hold, predicted target, sequential.
// Define FETCH_BHT_EN to predict conditional branches from a history
// table; without it every branch is predicted taken and resolve_* is ignored.
module fetch_pc_gen
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] inst,
    input  logic [31:0] predict_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_pred_taken,
    output logic        if_id_valid
);

    cf_kind_t    cf_kind;
    logic        branch_taken;
    logic        pred_taken;
    logic [31:0] next_pc;

    assign cf_kind = classify(inst[6:2]);

`ifdef FETCH_BHT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc[IDX_W+1:2]),
        .rd_taken  (branch_taken),
        .upd_valid (resolve_valid),
        .upd_idx   (resolve_pc[IDX_W+1:2]),
        .upd_taken (resolve_taken)
    );

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], resolve_pc[31:IDX_W+2], resolve_pc[1:0]};
`else
    assign branch_taken = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{redirect_pc[1:0], resolve_valid, resolve_pc, resolve_taken,
                           BHT_ENTRIES[0]};
`endif

    // Prediction: jumps always taken, conditional branches follow the branch predictor
    always_comb begin
        pred_taken = 1'b0;
        case (cf_kind)
            CF_JAL, CF_JALR: pred_taken = 1'b1;
            CF_BRANCH:       pred_taken = branch_taken;
            default:         pred_taken = 1'b0;
        endcase
    end

    // Next fetch address; redirect targets are forced word-aligned and pc+4 wraps naturally
    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect_valid) begin
            next_pc = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            next_pc = pc;
        end else if (pred_taken) begin
            next_pc = predict_pc;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // IF/ID register: a redirect squashes to a NOP bubble, a stall holds, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc         <= 32'h0000_0000;
            if_id_inst       <= NOP;
            if_id_pred_taken <= 1'b0;
            if_id_valid      <= 1'b0;
        end else if (redirect_valid) begin
            if_id_inst       <= NOP;
            if_id_pred_taken <= 1'b0;
            if_id_valid      <= 1'b0;
        end else if (!stall) begin
            if_id_pc         <= pc;
            if_id_inst       <= inst;
            if_id_pred_taken <= pred_taken;
            if_id_valid      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard testbench for fetch_pc_gen: directed scenarios plus random traffic,
// expected state from a behavioural model, compared by an independent monitor.
module tb_fetch_pc_gen;

    localparam int          BHT_N    = 16;
    localparam logic [31:0] RST_PC   = 32'h0040_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] ADDI     = 32'h0010_0093;
    localparam logic [31:0] JAL      = 32'h0380_006F;
    localparam logic [31:0] BEQ      = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] inst = ADDI;
    logic [31:0] predict_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        resolve_valid = 1'b0;
    logic [31:0] resolve_pc = '0;
    logic        resolve_taken = 1'b0;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;
    logic        if_id_pred_taken;
    logic        if_id_valid;

    always #5 clk = ~clk;

    fetch_pc_gen #(
        .RESET_PC    (RST_PC),
        .BHT_ENTRIES (BHT_N)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .inst             (inst),
        .predict_pc       (predict_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .pc               (pc),
        .if_id_pc         (if_id_pc),
        .if_id_inst       (if_id_inst),
        .if_id_pred_taken (if_id_pred_taken),
        .if_id_valid      (if_id_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifinst;
        logic        ifpred;
        logic        ifvalid;
    } exp_t;

    exp_t sb_queue[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_ifpc;
    logic [31:0] m_ifinst;
    logic        m_ifpred;
    logic        m_ifvalid;
    int          m_ctr [BHT_N];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelPredict(input logic [31:0] word, input logic [31:0] at);
        logic [4:0] op;
        int idx;
        op  = word[6:2];
        idx = int'((at >> 2) % BHT_N);
        if (op == 5'b11011 || op == 5'b11001) return 1'b1;
        if (op == 5'b11000) begin
`ifdef FETCH_BHT_EN
            return m_ctr[idx] >= 2;
`else
            return (idx >= 0);
`endif
        end
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, advance the model, queue the expected state, wait a cycle
    task automatic applyStimulus(input bit st, input bit rv, input logic [31:0] rpc,
                                 input logic [31:0] word, input logic [31:0] ppc,
                                 input bit resv, input logic [31:0] respc, input bit rest);
        exp_t        e;
        bit          p;
        logic [31:0] nxt;
        int          idx;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst           = word;
        predict_pc     = ppc;
        resolve_valid  = resv;
        resolve_pc     = respc;
        resolve_taken  = rest;

        p = modelPredict(word, m_pc);
        if (rv) begin
            nxt       = rpc & 32'hFFFF_FFFC;
            m_ifvalid = 1'b0;
            m_ifinst  = NOP_WORD;
            m_ifpred  = 1'b0;
        end else if (st) begin
            nxt = m_pc;
        end else begin
            nxt       = p ? ppc : m_pc + 32'd4;
            m_ifpc    = m_pc;
            m_ifinst  = word;
            m_ifpred  = p;
            m_ifvalid = 1'b1;
        end
        if (resv) begin
            idx = int'((respc >> 2) % BHT_N);
            if (rest) m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
            else      m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
        end
        m_pc = nxt;

        e.pc      = m_pc;
        e.ifpc    = m_ifpc;
        e.ifinst  = m_ifinst;
        e.ifpred  = m_ifpred;
        e.ifvalid = m_ifvalid;
        sb_queue.push_back(e);
        @(negedge clk);
    endtask

    // Assert reset between edges, check it acts at once, hold it over two edges, release
    task automatic doReset();
        rst       = 1'b1;
        m_pc      = RST_PC;
        m_ifpc    = 32'h0;
        m_ifinst  = NOP_WORD;
        m_ifpred  = 1'b0;
        m_ifvalid = 1'b0;
        for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
        #1;
        checkOutput("rst_pc", pc, RST_PC);
        checkOutput("rst_if_id_pc", if_id_pc, 32'h0);
        checkOutput("rst_if_id_inst", if_id_inst, NOP_WORD);
        checkOutput("rst_if_id_pred", {31'b0, if_id_pred_taken}, 32'h0);
        checkOutput("rst_if_id_valid", {31'b0, if_id_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pc_held", pc, RST_PC);
        rst = 1'b0;
    endtask

    // Monitor: after each active edge out of reset, pop the expected state and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_queue.size() > 0) begin
                e = sb_queue.pop_front();
                checkOutput("sb_pc", pc, e.pc);
                checkOutput("sb_if_id_pc", if_id_pc, e.ifpc);
                checkOutput("sb_if_id_inst", if_id_inst, e.ifinst);
                checkOutput("sb_if_id_pred", {31'b0, if_id_pred_taken}, {31'b0, e.ifpred});
                checkOutput("sb_if_id_valid", {31'b0, if_id_valid}, {31'b0, e.ifvalid});
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence
    initial begin
        logic [31:0] rnd;
        logic [31:0] word;
        logic [6:0]  opc;
        int          kind;

        @(negedge clk);
        doReset();

        // Sequential fetch out of reset
        applyStimulus(0, 0, 32'h0, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("seq_pc1", pc, 32'h0040_0004);
        checkOutput("seq_valid1", {31'b0, if_id_valid}, 32'h1);
        checkOutput("seq_if_id_pc1", if_id_pc, RST_PC);
        applyStimulus(0, 0, 32'h0, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("seq_pc2", pc, 32'h0040_0008);

        // JAL taken to the static target
        applyStimulus(0, 1, 32'h0040_001C, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("jal_setup_pc", pc, 32'h0040_001C);
        applyStimulus(0, 0, 32'h0, JAL, 32'h0040_0038, 0, 32'h0, 0);
        checkOutput("jal_pc", pc, 32'h0040_0038);
        checkOutput("jal_pred", {31'b0, if_id_pred_taken}, 32'h1);

        // Redirect wins over stall and squashes IF/ID
        applyStimulus(1, 1, 32'h0040_0013, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("redir_pc", pc, 32'h0040_0010);
        checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);
        checkOutput("redir_inst", if_id_inst, NOP_WORD);

        // Stall holds while training still happens
        applyStimulus(0, 0, 32'h0, ADDI, 32'h0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h0, BEQ, 32'h0040_0100, 1, 32'h0040_0014, 1);
        end
        checkOutput("stall_pc", pc, 32'h0040_0014);
        checkOutput("stall_if_id_pc", if_id_pc, 32'h0040_0010);
        applyStimulus(0, 0, 32'h0, BEQ, 32'h0040_0100, 0, 32'h0, 0);
        checkOutput("stall_trained_pc", pc, 32'h0040_0100);

`ifdef FETCH_BHT_EN
        // Branch history: weak not-taken, train taken, then saturate at zero
        applyStimulus(0, 1, 32'h0040_000C, ADDI, 32'h0, 0, 32'h0, 0);
        applyStimulus(0, 0, 32'h0, BEQ, 32'h0040_0034, 0, 32'h0, 0);
        checkOutput("bht_nt_pc", pc, 32'h0040_0010);
        applyStimulus(0, 1, 32'h0040_000C, ADDI, 32'h0, 1, 32'h0040_000C, 1);
        applyStimulus(0, 0, 32'h0, BEQ, 32'h0040_0034, 0, 32'h0, 0);
        checkOutput("bht_t_pc", pc, 32'h0040_0034);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 32'h0, ADDI, 32'h0, 1, 32'h0040_000C, 0);
        end
        applyStimulus(0, 1, 32'h0040_000C, ADDI, 32'h0, 1, 32'h0040_000C, 0);
        applyStimulus(0, 1, 32'h0040_000C, ADDI, 32'h0, 1, 32'h0040_000C, 1);
        applyStimulus(0, 0, 32'h0, BEQ, 32'h0040_0034, 0, 32'h0, 0);
        checkOutput("bht_sat_pc", pc, 32'h0040_0010);
`endif

        // Sequential increment wraps at the top of the address space
        applyStimulus(0, 1, 32'hFFFF_FFFC, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("wrap_setup_pc", pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'h0, ADDI, 32'h0, 0, 32'h0, 0);
        checkOutput("wrap_pc", pc, 32'h0000_0000);

        // Reset mid-stream with a redirect and update in flight
        applyStimulus(0, 0, 32'h0, ADDI, 32'h0, 0, 32'h0, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234_5678;
        resolve_valid  = 1'b1;
        resolve_pc     = 32'h0040_000C;
        resolve_taken  = 1'b1;
        doReset();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: opc = 7'b1100011;
                3:       opc = 7'b1101111;
                4:       opc = 7'b1100111;
                5:       begin rnd = $urandom(); opc = rnd[6:0]; end
                default: opc = 7'b0010011;
            endcase
            rnd  = $urandom();
            word = {rnd[31:7], opc};
            rnd  = $urandom();
            applyStimulus($urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) == 0,
                          32'h0040_0000 | (rnd & 32'h0000_03FF),
                          word,
                          32'h0040_0000 | ($urandom() & 32'h0000_03FC),
                          $urandom_range(0, 4) < 2,
                          32'h0040_0000 | ($urandom() & 32'h0000_00FC),
                          $urandom_range(0, 1) == 1);
        end

        @(negedge clk);
        checkOutput("sb_drain", sb_queue.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
